// File: rtl/picorv32_mem_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | picorv32_mem_slave_if : picorv32 native valid/ready memory bus  (Rev 1.0) |
// +--------------------------------------------------------------------------+
interface picorv32_mem_slave_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/picorv32_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | picorv32_mem_slave : wait-state memory, MMIO out reg, err flag, counters  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module picorv32_mem_slave #(
   parameter int          MEM_WORDS   = 256,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] MMIO_ADDR   = 32'h1000_0000,
   parameter int          CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   picorv32_mem_slave_if.slave  bus,
   output logic                 mmio_valid,
   output logic [31:0]          mmio_data,
   output logic                 err,
   output logic [CNT_W-1:0]     cnt_ifetch,
   output logic [CNT_W-1:0]     cnt_read,
   output logic [CNT_W-1:0]     cnt_write
);
   localparam int          c_idx_w     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [31:0] c_mem_bytes = 32'(MEM_WORDS * 4);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         wait_cnt_q, wait_cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic               instr_q, instr_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [31:0]        mmio_data_q, mmio_data_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_ifetch_q, cnt_ifetch_d;
   logic [CNT_W-1:0]   cnt_read_q, cnt_read_d;
   logic [CNT_W-1:0]   cnt_write_q, cnt_write_d;
   logic [31:0]        mem_q [MEM_WORDS];

   logic               resp, in_range, is_mmio, is_write, mem_we;
   logic [c_idx_w-1:0] idx;
   logic [31:0]        rd_word;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Decode always works on the latched request, never on the live bus.
   assign resp     = (state_q == ST_RESP);
   assign in_range = (addr_q < c_mem_bytes);
   assign is_mmio  = (addr_q[31:2] == MMIO_ADDR[31:2]);
   assign is_write = (wstrb_q != 4'b0000);
   assign idx      = addr_q[2 +: c_idx_w];
   assign mem_we   = resp && in_range && is_write;

   always_comb begin
      rd_word = 32'h0000_0000;
      if (in_range)     rd_word = mem_q[idx];
      else if (is_mmio) rd_word = mmio_data_q;
   end

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      instr_d      = instr_q;
      rdata_d      = rdata_q;
      mmio_data_d  = mmio_data_q;
      err_d        = err_q;
      cnt_ifetch_d = cnt_ifetch_q;
      cnt_read_d   = cnt_read_q;
      cnt_write_d  = cnt_write_q;
      mmio_valid   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.mem_valid) begin
               addr_d  = bus.mem_addr;
               wdata_d = bus.mem_wdata;
               wstrb_d = bus.mem_wstrb;
               instr_d = bus.mem_instr;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = 8'(WAIT_CYCLES - 1);
               end
            end
         end
         ST_WAIT: begin
            // A withdrawn request is dropped silently: no ready, no side effects.
            if (!bus.mem_valid)        state_d = ST_IDLE;
            else if (wait_cnt_q == 8'd0) state_d = ST_RESP;
            else                       wait_cnt_d = wait_cnt_q - 8'd1;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            rdata_d = rd_word;
            if (!in_range && is_mmio && is_write) begin
               mmio_valid  = 1'b1;
               mmio_data_d = merge(mmio_data_q, wdata_q, wstrb_q);
            end
            if (!in_range && !is_mmio) err_d = 1'b1;
            if (instr_q)       cnt_ifetch_d = sat_inc(cnt_ifetch_q);
            else if (is_write) cnt_write_d  = sat_inc(cnt_write_q);
            else               cnt_read_d   = sat_inc(cnt_read_q);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= 8'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         wstrb_q      <= 4'd0;
         instr_q      <= 1'b0;
         rdata_q      <= 32'd0;
         mmio_data_q  <= 32'd0;
         err_q        <= 1'b0;
         cnt_ifetch_q <= '0;
         cnt_read_q   <= '0;
         cnt_write_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         instr_q      <= instr_d;
         rdata_q      <= rdata_d;
         mmio_data_q  <= mmio_data_d;
         err_q        <= err_d;
         cnt_ifetch_q <= cnt_ifetch_d;
         cnt_read_q   <= cnt_read_d;
         cnt_write_q  <= cnt_write_d;
      end
   end

   // Array is deliberately not reset; a reset edge still blocks the commit.
   always_ff @(posedge clk) begin
      if (resetn && mem_we) mem_q[idx] <= merge(mem_q[idx], wdata_q, wstrb_q);
   end

   // Read data is the pre-write word, presented live during the response cycle.
   assign bus.mem_ready = resp;
   assign bus.mem_rdata = resp ? rd_word : rdata_q;
   assign mmio_data     = mmio_data_d;
   assign err           = err_q;
   assign cnt_ifetch    = cnt_ifetch_q;
   assign cnt_read      = cnt_read_q;
   assign cnt_write     = cnt_write_q;
endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_picorv32_mem_slave : directed bench over three slave configurations    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_picorv32_mem_slave;
   logic        clk = 1'b0;
   logic        rstn_a, rstn_b, rstn_c;
   logic        b_valid, b_instr;
   logic [31:0] b_addr, b_wdata;
   logic [3:0]  b_wstrb;
   int          sel;

   always #5 clk = ~clk;

   picorv32_mem_slave_if if_a ();
   picorv32_mem_slave_if if_b ();
   picorv32_mem_slave_if if_c ();

   assign if_a.mem_valid = b_valid && (sel == 0);
   assign if_a.mem_instr = b_instr;
   assign if_a.mem_addr  = b_addr;
   assign if_a.mem_wdata = b_wdata;
   assign if_a.mem_wstrb = b_wstrb;
   assign if_b.mem_valid = b_valid && (sel == 1);
   assign if_b.mem_instr = b_instr;
   assign if_b.mem_addr  = b_addr;
   assign if_b.mem_wdata = b_wdata;
   assign if_b.mem_wstrb = b_wstrb;
   assign if_c.mem_valid = b_valid && (sel == 2);
   assign if_c.mem_instr = b_instr;
   assign if_c.mem_addr  = b_addr;
   assign if_c.mem_wdata = b_wdata;
   assign if_c.mem_wstrb = b_wstrb;

   logic        mv_a, mv_b, mv_c, err_a, err_b, err_c;
   logic [31:0] md_a, md_b, md_c;
   logic [15:0] ci_a, cr_a, cw_a, ci_b, cr_b, cw_b;
   logic [1:0]  ci_c, cr_c, cw_c;

   picorv32_mem_slave #(.MEM_WORDS(256), .WAIT_CYCLES(0), .MMIO_ADDR(32'h1000_0000), .CNT_W(16)) u_dut_a (
      .clk(clk), .resetn(rstn_a), .bus(if_a.slave), .mmio_valid(mv_a), .mmio_data(md_a),
      .err(err_a), .cnt_ifetch(ci_a), .cnt_read(cr_a), .cnt_write(cw_a));
   picorv32_mem_slave #(.MEM_WORDS(256), .WAIT_CYCLES(3), .MMIO_ADDR(32'h1000_0000), .CNT_W(16)) u_dut_b (
      .clk(clk), .resetn(rstn_b), .bus(if_b.slave), .mmio_valid(mv_b), .mmio_data(md_b),
      .err(err_b), .cnt_ifetch(ci_b), .cnt_read(cr_b), .cnt_write(cw_b));
   picorv32_mem_slave #(.MEM_WORDS(256), .WAIT_CYCLES(5), .MMIO_ADDR(32'h1000_0000), .CNT_W(2)) u_dut_c (
      .clk(clk), .resetn(rstn_c), .bus(if_c.slave), .mmio_valid(mv_c), .mmio_data(md_c),
      .err(err_c), .cnt_ifetch(ci_c), .cnt_read(cr_c), .cnt_write(cw_c));

   logic        s_ready, s_mv;
   logic [31:0] s_rdata;
   always_comb begin
      s_ready = if_a.mem_ready;
      s_rdata = if_a.mem_rdata;
      s_mv    = mv_a;
      if (sel == 1) begin
         s_ready = if_b.mem_ready;
         s_rdata = if_b.mem_rdata;
         s_mv    = mv_b;
      end else if (sel == 2) begin
         s_ready = if_c.mem_ready;
         s_rdata = if_c.mem_rdata;
         s_mv    = mv_c;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus transaction; returns data, cycles from request to ready, and mmio_valid at ready.
   task automatic access(input int s, input logic instr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output logic [31:0] rd, output int lat, output logic mv);
      logic got;
      @(posedge clk); #1;
      sel = s; b_instr = instr; b_addr = a; b_wdata = wd; b_wstrb = ws; b_valid = 1'b1;
      lat = 0; got = 1'b0; rd = 32'd0; mv = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (s_ready) begin
            got = 1'b1;
            rd  = s_rdata;
            mv  = s_mv;
         end
      end
      b_valid = 1'b0;
      check_eq("ready_seen", 32'(got), 32'd1);
   endtask

   logic [31:0] rd, model;
   logic        mv;
   int          lat, seen;
   logic [31:0] prog [4];

   initial begin
      prog[0] = 32'h0000_A103;   // lw   x2,0(x1)
      prog[1] = 32'h0011_0113;   // addi x2,x2,1
      prog[2] = 32'h0020_A023;   // sw   x2,0(x1)
      prog[3] = 32'hFF5F_F06F;   // j    loop
      sel = 0; b_valid = 1'b0; b_instr = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_wstrb = 4'd0;
      rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;

      check_eq("rst_ready", 32'(if_a.mem_ready), 32'd0);
      check_eq("rst_rdata", if_a.mem_rdata, 32'd0);
      check_eq("rst_mmio_valid", 32'(mv_a), 32'd0);
      check_eq("rst_mmio_data", md_a, 32'd0);
      check_eq("rst_err", 32'(err_a), 32'd0);
      check_eq("rst_cnts", {ci_a, cr_a | cw_a}, 32'd0);

      // Legacy loop traffic, zero wait states
      for (int i = 0; i < 4; i++) begin
         access(0, 1'b0, 32'(i * 4), prog[i], 4'hF, rd, lat, mv);
         check_eq("load_lat", 32'(lat), 32'd1);
      end
      model = 32'd1;
      access(0, 1'b0, 32'd1020, model, 4'hF, rd, lat, mv);
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 4; p++) begin
            access(0, 1'b1, 32'(p * 4), 32'd0, 4'h0, rd, lat, mv);
            check_eq("fetch_word", rd, prog[p]);
            check_eq("fetch_lat", 32'(lat), 32'd1);
            if (p == 0) begin
               access(0, 1'b0, 32'd1020, 32'd0, 4'h0, rd, lat, mv);
               check_eq("loop_lw", rd, model);
               model = model + 32'd1;
            end else if (p == 2) begin
               access(0, 1'b0, 32'd1020, model, 4'hF, rd, lat, mv);
            end
         end
      end
      @(posedge clk); #1;
      check_eq("loop_ifetch", 32'(ci_a), 32'd12);
      check_eq("loop_read", 32'(cr_a), 32'd3);
      check_eq("loop_write", 32'(cw_a), 32'd8);
      check_eq("loop_err", 32'(err_a), 32'd0);

      // Byte-lane write: lanes 0 and 2 take the new bytes
      access(0, 1'b0, 32'd32, 32'h1122_3344, 4'hF, rd, lat, mv);
      access(0, 1'b0, 32'd32, 32'hAABB_CCDD, 4'b0101, rd, lat, mv);
      check_eq("strb_prewrite", rd, 32'h1122_3344);
      access(0, 1'b0, 32'd32, 32'd0, 4'h0, rd, lat, mv);
      check_eq("strb_merge", rd, 32'h11BB_33DD);

      // MMIO register
      access(0, 1'b0, 32'h1000_0000, 32'h1234_5678, 4'hF, rd, lat, mv);
      check_eq("mmio_pulse", 32'(mv), 32'd1);
      check_eq("mmio_data_pulse", md_a, 32'h1234_5678);
      @(posedge clk); #1;
      check_eq("mmio_pulse_end", 32'(mv_a), 32'd0);
      check_eq("mmio_data_hold", md_a, 32'h1234_5678);
      check_eq("mmio_cnt_write", 32'(cw_a), 32'd11);
      check_eq("mmio_err", 32'(err_a), 32'd0);
      access(0, 1'b0, 32'h1000_0000, 32'hAB00_0000, 4'b1000, rd, lat, mv);
      check_eq("mmio_partial", md_a, 32'hAB34_5678);
      access(0, 1'b0, 32'h1000_0000, 32'd0, 4'h0, rd, lat, mv);
      check_eq("mmio_read", rd, 32'hAB34_5678);
      check_eq("mmio_read_nopulse", 32'(mv), 32'd0);

      // Out-of-range read: first byte past the array
      access(0, 1'b0, 32'd1024, 32'd0, 4'h0, rd, lat, mv);
      check_eq("oor_lat", 32'(lat), 32'd1);
      check_eq("oor_rdata", rd, 32'd0);
      @(posedge clk); #1;
      check_eq("oor_err", 32'(err_a), 32'd1);
      access(0, 1'b0, 32'd32, 32'd0, 4'h0, rd, lat, mv);
      check_eq("oor_after_read", rd, 32'h11BB_33DD);
      @(posedge clk); #1;
      check_eq("oor_err_sticky", 32'(err_a), 32'd1);
      check_eq("final_read_cnt", 32'(cr_a), 32'd7);
      check_eq("final_write_cnt", 32'(cw_a), 32'd12);

      // Three wait states
      access(1, 1'b0, 32'd16, 32'h0BAD_F00D, 4'hF, rd, lat, mv);
      check_eq("w3_write_lat", 32'(lat), 32'd4);
      access(1, 1'b0, 32'd16, 32'd0, 4'h0, rd, lat, mv);
      check_eq("w3_read_lat", 32'(lat), 32'd4);
      check_eq("w3_read_data", rd, 32'h0BAD_F00D);

      // Request withdrawn during WAIT
      @(posedge clk); #1;
      sel = 1; b_instr = 1'b0; b_addr = 32'd16; b_wdata = 32'h5555_5555; b_wstrb = 4'hF; b_valid = 1'b1;
      seen = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (if_b.mem_ready) seen++;
      end
      b_valid = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (if_b.mem_ready) seen++;
      end
      check_eq("abort_no_ready", 32'(seen), 32'd0);
      check_eq("abort_cnt_write", 32'(cw_b), 32'd1);
      access(1, 1'b0, 32'd16, 32'd0, 4'h0, rd, lat, mv);
      check_eq("abort_no_write", rd, 32'h0BAD_F00D);

      // Reset in the middle of a WAIT_CYCLES=5 write
      access(2, 1'b0, 32'd8, 32'hCAFE_F00D, 4'hF, rd, lat, mv);
      check_eq("w5_lat", 32'(lat), 32'd6);
      @(posedge clk); #1;
      sel = 2; b_instr = 1'b0; b_addr = 32'd8; b_wdata = 32'hDEAD_BEEF; b_wstrb = 4'hF; b_valid = 1'b1;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (if_c.mem_ready) seen++;
      end
      rstn_c = 1'b0; b_valid = 1'b0;
      @(posedge clk); #1;
      rstn_c = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (if_c.mem_ready) seen++;
      end
      check_eq("rstwait_no_ready", 32'(seen), 32'd0);
      check_eq("rstwait_cnts", {26'd0, ci_c, cr_c, cw_c}, 32'd0);
      access(2, 1'b0, 32'd8, 32'd0, 4'h0, rd, lat, mv);
      check_eq("rstwait_word", rd, 32'hCAFE_F00D);
      for (int i = 0; i < 5; i++) access(2, 1'b1, 32'd8, 32'd0, 4'h0, rd, lat, mv);
      @(posedge clk); #1;
      check_eq("sat_ifetch", 32'(ci_c), 32'd3);
      check_eq("sat_read", 32'(cr_c), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
